// File: rtl/i2c_pkg.sv
// Shared types and default timing for the I2C bus arbiter and its helpers.
package i2c_pkg;

    // Arbiter ownership states.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PI_OWN     = 3'd1,
        INT_OWN    = 3'd2,
        PI_WAIT    = 3'd3,
        REPLAY_SDA = 3'd4,
        REPLAY_SCL = 3'd5,
        HANDOVER   = 3'd6,
        BUS_FREE   = 3'd7
    } arb_state_e;

    localparam int SYNC_STAGES_DEF       = 2;
    localparam int BUS_FREE_CYCLES_DEF   = 64;
    localparam int START_HOLD_CYCLES_DEF = 48;
    localparam int TIMEOUT_W_DEF         = 20;

    // Largest of three widths; sizes the single shared down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/i2c_cond_detect.sv
// Synchronises raw SCL/SDA and produces START, STOP and SCL-edge pulses.
// Pulses are combinational off the synchronised levels, so a consumer that
// registers them sees a pin change SYNC_STAGES+1 clocks later.
module i2c_cond_detect
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic s_scl_o,
    output logic start_o,
    output logic stop_o,
    output logic scl_edge_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   s_scl;
    logic                   s_sda;

    assign s_scl = scl_sync_q[SYNC_STAGES-1];
    assign s_sda = sda_sync_q[SYNC_STAGES-1];

    // Synchroniser chains plus one-cycle history for edge detection; idle bus reads high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= s_scl;
            sda_prev_q <= s_sda;
        end
    end

    assign s_scl_o    = s_scl;
    assign start_o    = sda_prev_q & ~s_sda & s_scl;
    assign stop_o     = ~sda_prev_q & s_sda & s_scl;
    assign scl_edge_o = scl_prev_q ^ s_scl;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares the peripheral I2C bus between the Pi passthrough and the internal
// master. A Pi START seen while the internal master owns the bus is held off
// by stretching Pi SCL, then replayed on the peripheral side before handover.
//
// state      | meaning
// IDLE       | bus free, nobody owns it
// PI_OWN     | passthrough enabled, Pi drives the bus
// INT_OWN    | internal master granted
// PI_WAIT    | Pi START pending behind internal master; Pi SCL stretched
// REPLAY_SDA | replaying START: peripheral SDA low, SCL high
// REPLAY_SCL | replaying START: peripheral SCL pulled low too
// HANDOVER   | passthrough on while pulls still held, then PI_OWN
// BUS_FREE   | bus-free guard time after STOP / internal done / timeout
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES       = SYNC_STAGES_DEF,
    parameter int BUS_FREE_CYCLES   = BUS_FREE_CYCLES_DEF,
    parameter int START_HOLD_CYCLES = START_HOLD_CYCLES_DEF,
    parameter int TIMEOUT_W         = TIMEOUT_W_DEF
) (
    input  logic ICE_CLK,
    input  logic ICE_RST_N,
    input  logic pi_scl_i,
    input  logic pi_sda_i,
    input  logic int_req,
    input  logic int_done,
    output logic passthru_en,
    output logic int_grant,
    output logic pi_scl_hold,
    output logic periph_sda_pull,
    output logic periph_scl_pull,
    output logic bus_busy
);

    localparam int CNT_W = max3(TIMEOUT_W, $clog2(BUS_FREE_CYCLES + 1),
                                $clog2(START_HOLD_CYCLES + 1));

    // Loads are N-1 because the terminal compare happens on the count==0 cycle.
    localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'((2 ** TIMEOUT_W) - 2);
    localparam logic [CNT_W-1:0] FREE_LOAD = CNT_W'(BUS_FREE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(START_HOLD_CYCLES - 1);

    logic rst_meta_q;
    logic rst_n;

    logic s_scl;
    logic start_p;
    logic stop_p;
    logic scl_edge_p;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             hold_q, hold_d;
    logic             passthru_q, grant_q, sda_pull_q, scl_pull_q, busy_q;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N) begin
            rst_meta_q <= 1'b0;
            rst_n      <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n      <= rst_meta_q;
        end
    end

    i2c_cond_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cond (
        .clk_i     (ICE_CLK),
        .rst_ni    (rst_n),
        .scl_i     (pi_scl_i),
        .sda_i     (pi_sda_i),
        .s_scl_o   (s_scl),
        .start_o   (start_p),
        .stop_o    (stop_p),
        .scl_edge_o(scl_edge_p)
    );

    // Next-state, shared counter and pending-done flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (start_p) begin
                    state_d = PI_OWN;
                    cnt_d   = TMO_LOAD;
                end else if (int_req) begin
                    state_d = INT_OWN;
                end
            end
            PI_OWN: begin
                if (stop_p) begin
                    state_d = BUS_FREE;
                    cnt_d   = FREE_LOAD;
                end else if (scl_edge_p) begin
                    cnt_d = TMO_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = BUS_FREE;
                    cnt_d   = FREE_LOAD;
                end
            end
            INT_OWN: begin
                if (start_p) begin
                    // A simultaneous int_done is remembered so its guard time starts now.
                    state_d = PI_WAIT;
                    done_d  = int_done;
                    cnt_d   = FREE_LOAD;
                end else if (int_done) begin
                    state_d = BUS_FREE;
                    cnt_d   = FREE_LOAD;
                end
            end
            PI_WAIT: begin
                if (!done_q) begin
                    if (int_done) begin
                        done_d = 1'b1;
                        cnt_d  = FREE_LOAD;
                    end
                end else if (cnt_q == '0) begin
                    state_d = REPLAY_SDA;
                    done_d  = 1'b0;
                    cnt_d   = HOLD_LOAD;
                end
            end
            REPLAY_SDA: begin
                if (cnt_q == '0) state_d = REPLAY_SCL;
            end
            REPLAY_SCL: begin
                state_d = HANDOVER;
            end
            HANDOVER: begin
                state_d = PI_OWN;
                cnt_d   = TMO_LOAD;
            end
            BUS_FREE: begin
                if (start_p) begin
                    state_d = PI_OWN;
                    cnt_d   = TMO_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Stretch is only raised once synchronised SCL is low, then held until PI_OWN.
    always_comb begin
        hold_d = 1'b0;
        if (state_d == PI_WAIT || state_d == REPLAY_SDA ||
            state_d == REPLAY_SCL || state_d == HANDOVER) begin
            hold_d = hold_q | ~s_scl;
        end
    end

    // State, counter and Moore outputs registered from the next state.
    always_ff @(posedge ICE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            hold_q     <= 1'b0;
            passthru_q <= 1'b0;
            grant_q    <= 1'b0;
            sda_pull_q <= 1'b0;
            scl_pull_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            hold_q     <= hold_d;
            passthru_q <= (state_d == PI_OWN) || (state_d == HANDOVER);
            grant_q    <= (state_d == INT_OWN) || (state_d == PI_WAIT && !done_d);
            sda_pull_q <= (state_d == REPLAY_SDA) || (state_d == REPLAY_SCL) ||
                          (state_d == HANDOVER);
            scl_pull_q <= (state_d == REPLAY_SCL) || (state_d == HANDOVER);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign passthru_en     = passthru_q;
    assign int_grant       = grant_q;
    assign pi_scl_hold     = hold_q;
    assign periph_sda_pull = sda_pull_q;
    assign periph_scl_pull = scl_pull_q;
    assign bus_busy        = busy_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter. Outputs are packed as
// {passthru_en, int_grant, pi_scl_hold, periph_sda_pull, periph_scl_pull, bus_busy}.
module tb_i2c_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda = 1'b1;
    logic int_req = 1'b0;
    logic int_done = 1'b0;
    logic passthru_en, int_grant, pi_scl_hold, periph_sda_pull, periph_scl_pull, bus_busy;
    logic [5:0] outs;
    int n_cmp = 0;
    int n_err = 0;

    assign outs = {passthru_en, int_grant, pi_scl_hold, periph_sda_pull, periph_scl_pull, bus_busy};

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .SYNC_STAGES(2),
        .BUS_FREE_CYCLES(64),
        .START_HOLD_CYCLES(48),
        .TIMEOUT_W(8)
    ) dut (
        .ICE_CLK        (clk),
        .ICE_RST_N      (rst_n),
        .pi_scl_i       (scl),
        .pi_sda_i       (sda),
        .int_req        (int_req),
        .int_done       (int_done),
        .passthru_en    (passthru_en),
        .int_grant      (int_grant),
        .pi_scl_hold    (pi_scl_hold),
        .periph_sda_pull(periph_sda_pull),
        .periph_scl_pull(periph_scl_pull),
        .bus_busy       (bus_busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pi_clocks(input int n);
        repeat (n) begin
            scl = 1'b0; tick(4);
            scl = 1'b1; tick(4);
        end
    endtask

    // Leaves SDA rising with SCL high at the current negedge.
    task automatic pi_stop();
        scl = 1'b0; sda = 1'b0; tick(4);
        scl = 1'b1; tick(4);
        sda = 1'b1;
    endtask

    task automatic pulse_done();
        int_done = 1'b1; tick(1); int_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(3);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_held: got %b want %b", outs, 6'b000000); end
        rst_n = 1'b1; tick(4);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_released: got %b want %b", outs, 6'b000000); end
    endtask

    task automatic test_pi_transfer();
        sda = 1'b0; tick(2);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t1_latency: got %b want %b", outs, 6'b000000); end
        tick(1);
        n_cmp++; if (outs !== 6'b100001) begin n_err++; $display("FAIL t1_pi_own: got %b want %b", outs, 6'b100001); end
        pi_clocks(18);
        n_cmp++; if (outs !== 6'b100001) begin n_err++; $display("FAIL t1_after_bytes: got %b want %b", outs, 6'b100001); end
        pi_stop(); tick(2);
        n_cmp++; if (outs !== 6'b100001) begin n_err++; $display("FAIL t1_stop_latency: got %b want %b", outs, 6'b100001); end
        tick(1);
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL t1_bus_free: got %b want %b", outs, 6'b000001); end
        tick(63);
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL t1_free_last: got %b want %b", outs, 6'b000001); end
        tick(1);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t1_idle: got %b want %b", outs, 6'b000000); end
    endtask

    task automatic test_int_master();
        int_req = 1'b1; tick(1);
        n_cmp++; if (outs !== 6'b010001) begin n_err++; $display("FAIL t2_grant: got %b want %b", outs, 6'b010001); end
        int_req = 1'b0; tick(5);
        n_cmp++; if (outs !== 6'b010001) begin n_err++; $display("FAIL t2_grant_held: got %b want %b", outs, 6'b010001); end
        pulse_done();
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL t2_done: got %b want %b", outs, 6'b000001); end
        tick(63);
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL t2_free_last: got %b want %b", outs, 6'b000001); end
        tick(1);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t2_idle: got %b want %b", outs, 6'b000000); end
    endtask

    task automatic test_simultaneous();
        sda = 1'b0; tick(2);
        int_req = 1'b1; tick(1);
        n_cmp++; if (outs !== 6'b100001) begin n_err++; $display("FAIL t3_pi_wins: got %b want %b", outs, 6'b100001); end
        pi_clocks(18);
        n_cmp++; if (outs !== 6'b100001) begin n_err++; $display("FAIL t3_req_pending: got %b want %b", outs, 6'b100001); end
        pi_stop(); tick(3);
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL t3_free: got %b want %b", outs, 6'b000001); end
        tick(63);
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL t3_no_grant_in_free: got %b want %b", outs, 6'b000001); end
        tick(1);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t3_idle: got %b want %b", outs, 6'b000000); end
        tick(1);
        n_cmp++; if (outs !== 6'b010001) begin n_err++; $display("FAIL t3_late_grant: got %b want %b", outs, 6'b010001); end
        int_req = 1'b0; tick(2);
        pulse_done(); tick(64);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t3_final_idle: got %b want %b", outs, 6'b000000); end
    endtask

    task automatic test_pi_wait_replay();
        int_req = 1'b1; tick(1);
        int_req = 1'b0; tick(2);
        sda = 1'b0; tick(3);
        n_cmp++; if (outs !== 6'b010001) begin n_err++; $display("FAIL t4_wait_no_hold: got %b want %b", outs, 6'b010001); end
        scl = 1'b0; tick(2);
        n_cmp++; if (outs !== 6'b010001) begin n_err++; $display("FAIL t4_hold_latency: got %b want %b", outs, 6'b010001); end
        tick(1);
        n_cmp++; if (outs !== 6'b011001) begin n_err++; $display("FAIL t4_hold: got %b want %b", outs, 6'b011001); end
        tick(5);
        pulse_done();
        n_cmp++; if (outs !== 6'b001001) begin n_err++; $display("FAIL t4_done: got %b want %b", outs, 6'b001001); end
        tick(63);
        n_cmp++; if (outs !== 6'b001001) begin n_err++; $display("FAIL t4_guard_last: got %b want %b", outs, 6'b001001); end
        tick(1);
        n_cmp++; if (outs !== 6'b001101) begin n_err++; $display("FAIL t4_sda_pull: got %b want %b", outs, 6'b001101); end
        tick(47);
        n_cmp++; if (outs !== 6'b001101) begin n_err++; $display("FAIL t4_sda_pull_last: got %b want %b", outs, 6'b001101); end
        tick(1);
        n_cmp++; if (outs !== 6'b001111) begin n_err++; $display("FAIL t4_scl_pull: got %b want %b", outs, 6'b001111); end
        tick(1);
        n_cmp++; if (outs !== 6'b101111) begin n_err++; $display("FAIL t4_handover: got %b want %b", outs, 6'b101111); end
        tick(1);
        n_cmp++; if (outs !== 6'b100001) begin n_err++; $display("FAIL t4_pi_own: got %b want %b", outs, 6'b100001); end
        pi_clocks(9);
        pi_stop(); tick(3);
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL t4_free: got %b want %b", outs, 6'b000001); end
        tick(64);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t4_idle: got %b want %b", outs, 6'b000000); end
    endtask

    task automatic test_timeout();
        sda = 1'b0; tick(3);
        n_cmp++; if (outs !== 6'b100001) begin n_err++; $display("FAIL t5_pi_own: got %b want %b", outs, 6'b100001); end
        tick(254);
        n_cmp++; if (outs !== 6'b100001) begin n_err++; $display("FAIL t5_last_own: got %b want %b", outs, 6'b100001); end
        tick(1);
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL t5_abandoned: got %b want %b", outs, 6'b000001); end
        sda = 1'b1; tick(64);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t5_idle: got %b want %b", outs, 6'b000000); end
    endtask

    task automatic test_reset_mid_replay();
        int_req = 1'b1; tick(1);
        int_req = 1'b0;
        sda = 1'b0; tick(3);
        scl = 1'b0; tick(3);
        pulse_done(); tick(64);
        n_cmp++; if (outs !== 6'b001101) begin n_err++; $display("FAIL t6_in_replay: got %b want %b", outs, 6'b001101); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t6_async_clear: got %b want %b", outs, 6'b000000); end
        sda = 1'b1; scl = 1'b1; tick(2);
        rst_n = 1'b1; tick(4);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t6_idle_after_reset: got %b want %b", outs, 6'b000000); end
        int_req = 1'b1; tick(1);
        n_cmp++; if (outs !== 6'b010001) begin n_err++; $display("FAIL t6_recover_grant: got %b want %b", outs, 6'b010001); end
        int_req = 1'b0; pulse_done(); tick(64);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t6_recover_idle: got %b want %b", outs, 6'b000000); end
    endtask

    task automatic test_back_to_back();
        pulse_done(); tick(1);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t7_stray_done: got %b want %b", outs, 6'b000000); end
        sda = 1'b0; tick(3);
        pi_clocks(9);
        pi_stop(); tick(3);
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL t7_first_free: got %b want %b", outs, 6'b000001); end
        tick(10);
        sda = 1'b0; tick(3);
        n_cmp++; if (outs !== 6'b100001) begin n_err++; $display("FAIL t7_start_in_free: got %b want %b", outs, 6'b100001); end
        pi_clocks(9);
        pi_stop(); tick(67);
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL t7_idle: got %b want %b", outs, 6'b000000); end
    endtask

    initial begin
        test_reset();
        test_pi_transfer();
        test_int_master();
        test_simultaneous();
        test_pi_wait_replay();
        test_timeout();
        test_reset_mid_replay();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
